// File: rtl/dispatch_buffer.sv
// -----------------------------------------------------------------------------
// dispatch_buffer
//
// Decoupling FIFO between decode and the out-of-order core. Up to N compacted
// decode lanes are written per cycle. The N oldest entries are presented, in
// program order, to the dispatch port. The core either takes every presented
// lane or none of them.
//
// Ports
//   clock              single clock; all state changes on its rising edge
//   reset              asynchronous active-low reset
//   in_valid  [N]      decode lane valids (compacted, lane 0 oldest)
//   in_entry  [N]      decode lane payloads, ENTRY_W bits each
//   in_ready           at least N free slots (registered count only)
//   out_valid [N]      dispatch lane valids (compacted)
//   out_entry [N]      oldest entries, lane 0 is the head
//   structural_hazard  core cannot take a dispatch this cycle
//   squash             discard all contents at the next edge
//   count              occupied entries, registered
// -----------------------------------------------------------------------------
`ifndef N
`define N 2
`endif

module dispatch_buffer #(
    parameter int N       = `N,
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = 128,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N-1:0]                in_valid,
    input  logic [N-1:0][ENTRY_W-1:0]   in_entry,
    output logic                        in_ready,
    output logic [N-1:0]                out_valid,
    output logic [N-1:0][ENTRY_W-1:0]   out_entry,
    input  logic                        structural_hazard,
    input  logic                        squash,
    output logic [CNT_W-1:0]            count
);

    localparam int                PTR_W     = $clog2(DEPTH);
    localparam logic [CNT_W-1:0]  READY_MAX = CNT_W'(DEPTH - N);
    localparam logic [CNT_W-1:0]  LANES     = CNT_W'(N);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               enq;
    logic               deq;
    logic [CNT_W-1:0]   k_in;
    logic [CNT_W-1:0]   k_acc;
    logic [CNT_W-1:0]   d_take;

    // Readiness looks only at registered occupancy; a same-cycle dispatch is
    // ignored, so the buffer stalls one cycle early with N-1 slots free.
    assign in_ready = (count_q <= READY_MAX);
    assign count    = count_q;

    assign enq = in_ready && !squash;
    assign deq = !structural_hazard && !squash;

    // Lane count offered by decode. Lanes are compacted, so the popcount is
    // also the index of the first invalid lane.
    always_comb begin
        k_in = '0;
        for (int i = 0; i < N; i++) begin
            k_in = k_in + CNT_W'(in_valid[i]);
        end
    end

    assign k_acc  = enq ? k_in : '0;
    assign d_take = !deq ? '0 : ((count_q < LANES) ? count_q : LANES);

    // Presentation is purely from registered state; there is no bypass from
    // the decode lanes.
    always_comb begin
        out_valid = '0;
        out_entry = '0;
        for (int i = 0; i < N; i++) begin
            out_valid[i] = (CNT_W'(i) < count_q) && !squash;
            out_entry[i] = mem_q[head_q + PTR_W'(i)];
        end
    end

    // Next-state pointers and occupancy. Squash overrides both the enqueue
    // and the dispatch of the same cycle.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (squash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            // Pointers wrap modulo DEPTH by natural overflow.
            head_d  = head_q + PTR_W'(d_take);
            tail_d  = tail_q + PTR_W'(k_acc);
            count_d = count_q + k_acc - d_take;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: the storage array has no reset; validity is carried entirely by
    // count_q, so clearing the payload words would only cost reset fan-out.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (enq && (CNT_W'(i) < k_in)) begin
                mem_q[tail_q + PTR_W'(i)] <= in_entry[i];
            end
        end
    end

endmodule

// File: tb/tb_dispatch_buffer.sv
// -----------------------------------------------------------------------------
// tb_dispatch_buffer
//
// Drives dispatch_buffer (N=2, DEPTH=8, ENTRY_W=128) through directed
// scenarios followed by a randomized phase. The reference is a plain queue of
// entries in program order: dispatch pops from the front, enqueue pushes to
// the back, squash empties it.
// -----------------------------------------------------------------------------
module tb_dispatch_buffer;

    localparam int N       = 2;
    localparam int DEPTH   = 8;
    localparam int ENTRY_W = 128;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic                       clock = 1'b0;
    logic                       reset = 1'b1;
    logic [N-1:0]               in_valid = '0;
    logic [N-1:0][ENTRY_W-1:0]  in_entry = '0;
    logic                       in_ready;
    logic [N-1:0]               out_valid;
    logic [N-1:0][ENTRY_W-1:0]  out_entry;
    logic                       structural_hazard = 1'b0;
    logic                       squash = 1'b0;
    logic [CNT_W-1:0]           count;

    int checks = 0;
    int errors = 0;
    int seq    = 0;

    logic [ENTRY_W-1:0] model_q [$];

    dispatch_buffer #(
        .N       (N),
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_entry          (in_entry),
        .in_ready          (in_ready),
        .out_valid         (out_valid),
        .out_entry         (out_entry),
        .structural_hazard (structural_hazard),
        .squash            (squash),
        .count             (count)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [ENTRY_W-1:0] obs,
                         input logic [ENTRY_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Unique payload: random upper bits, program-order sequence number below.
    function automatic logic [ENTRY_W-1:0] make_entry();
        logic [ENTRY_W-1:0] e;
        seq++;
        e = {$urandom(), $urandom(), $urandom(), 32'(seq)};
        return e;
    endfunction

    // One clock cycle, entered and left just after a falling edge. Inputs are
    // applied, outputs compared against the queue, then the queue advances
    // with the rising edge.
    task automatic step(input logic [N-1:0] v, input logic hz, input logic sq,
                        input string tag);
        int           occ;
        bit           rdy;
        int           d;
        logic [N-1:0] exp_ov;
        in_valid          = v;
        structural_hazard = hz;
        squash            = sq;
        for (int i = 0; i < N; i++) in_entry[i] = make_entry();
        #1;
        occ = model_q.size();
        rdy = (DEPTH - occ) >= N;
        exp_ov = '0;
        for (int i = 0; i < N; i++) exp_ov[i] = (i < occ) && !sq;
        check({tag, ".count"},     ENTRY_W'(count),     ENTRY_W'(occ));
        check({tag, ".in_ready"},  ENTRY_W'(in_ready),  ENTRY_W'(rdy));
        check({tag, ".out_valid"}, ENTRY_W'(out_valid), ENTRY_W'(exp_ov));
        for (int i = 0; i < N; i++) begin
            if (exp_ov[i]) begin
                check($sformatf("%s.out_entry%0d", tag, i), out_entry[i], model_q[i]);
            end
        end
        @(posedge clock);
        if (sq) begin
            model_q.delete();
        end else begin
            if (!hz) begin
                d = (occ < N) ? occ : N;
                repeat (d) void'(model_q.pop_front());
            end
            if (rdy) begin
                for (int i = 0; i < N; i++) begin
                    if (v[i]) model_q.push_back(in_entry[i]);
                end
            end
        end
        @(negedge clock);
    endtask

    initial begin
        logic [N-1:0] rv;
        int           r;

        // Reset state.
        #1 reset = 1'b0;
        #1;
        check("reset.count",     ENTRY_W'(count),     '0);
        check("reset.in_ready",  ENTRY_W'(in_ready),  ENTRY_W'(1));
        check("reset.out_valid", ENTRY_W'(out_valid), '0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Full-rate streaming with no hazard: settles at two in flight.
        for (int c = 0; c < 10; c++) step(2'b11, 1'b0, 1'b0, "stream");

        // Hazard held: fill until in_ready falls, outputs must stay put.
        for (int c = 0; c < 5; c++) step(2'b11, 1'b1, 1'b0, "hazard_fill");
        // Release: drain two per cycle in order.
        for (int c = 0; c < 5; c++) step(2'b00, 1'b0, 1'b0, "drain");

        // Fill to seven, offer one lane while not ready, then dispatch two.
        for (int c = 0; c < 3; c++) step(2'b11, 1'b1, 1'b0, "fill6");
        step(2'b01, 1'b1, 1'b0, "fill7");
        step(2'b01, 1'b1, 1'b0, "blocked");
        step(2'b00, 1'b0, 1'b0, "disp2");

        // count=5: squash with a full decode pair and a hazard; squash wins.
        step(2'b11, 1'b1, 1'b1, "squash");
        step(2'b00, 1'b1, 1'b0, "post_squash");

        // count=1: enqueue two while the old entry dispatches.
        step(2'b01, 1'b1, 1'b0, "one");
        step(2'b11, 1'b0, 1'b0, "enq_deq");
        step(2'b00, 1'b1, 1'b0, "pair_held");

        // Randomized traffic with occasional squashes.
        for (int c = 0; c < 300; c++) begin
            r  = int'($urandom_range(0, 2));
            rv = (r == 0) ? 2'b00 : ((r == 1) ? 2'b01 : 2'b11);
            step(rv, ($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0), "random");
        end

        // Build occupancy, then assert reset between edges.
        for (int c = 0; c < 3; c++) step(2'b11, 1'b1, 1'b0, "pre_reset");
        in_valid          = 2'b11;
        structural_hazard = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("async_reset.count",     ENTRY_W'(count),     '0);
        check("async_reset.out_valid", ENTRY_W'(out_valid), '0);
        check("async_reset.in_ready",  ENTRY_W'(in_ready),  ENTRY_W'(1));
        model_q.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        step(2'b11, 1'b0, 1'b0, "after_reset");
        step(2'b00, 1'b1, 1'b0, "after_reset_hold");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
